// File: rtl/my_cpu_seq_pkg.sv
// Shared types and constants for the Hack CPU run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package my_cpu_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int PC_W   = 15;

  // "0;JMP" - the unconditional jump closing the canonical end loop.
  localparam logic [WORD_W-1:0] HALT_INSTR = 16'hEA87;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HI,
    ST_LOAD_LO,
    ST_RST_PULSE,
    ST_RUN,
    ST_HALTED
  } seq_state_t;

endpackage

// File: rtl/my_cpu_seq_loader.sv
// Byte-to-word assembler and ROM write pointer for program loading.
// Latency: rom_we pulses one cycle after the byte that completes a word is accepted.
// Backpressure: none internally; the parent only raises the accept strobes while load_ready is high.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clear                 restart the write pointer at address 0
//   hi_accept/lo_accept   byte accepted in the high/low phase of a word
//   last, data            final-byte flag and byte value of the accepted byte
//   rom_we/addr/wdata     registered ROM write port
module my_cpu_seq_loader
  import my_cpu_seq_pkg::*;
#(
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hi_accept,
  input  logic              lo_accept,
  input  logic              last,
  input  logic [BYTE_W-1:0] data,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata
);

  logic [BYTE_W-1:0] hi_q;
  logic [ROM_AW-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      ptr       <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
    end else begin
      rom_we <= 1'b0;
      if (clear) begin
        ptr <= '0;
      end else if (hi_accept) begin
        hi_q <= data;
        // A program ending on a high byte still produces a word, padded low.
        if (last) begin
          rom_we    <= 1'b1;
          rom_addr  <= ptr;
          rom_wdata <= {data, {BYTE_W{1'b0}}};
          ptr       <= ptr + 1'b1;
        end
      end else if (lo_accept) begin
        rom_we    <= 1'b1;
        rom_addr  <= ptr;
        rom_wdata <= {hi_q, data};
        ptr       <= ptr + 1'b1;   // wraps to 0 past the top of the ROM
      end
    end
  end

endmodule

// File: rtl/my_cpu_sequencer.sv
// Run controller for the Hack CPU: program load, CPU reset pulse, run and halt detection.
// Latency: rom_we 1 cycle after a word completes; halted/halt_pc 1 cycle after the halt condition.
// Backpressure: load_ready high only in the load states; run/load_start ignored while busy.
//
// Ports: clk/reset (async active-high); load_start/load_valid/load_ready/load_data/load_last
// byte stream in; run/stop control; pc/instruction observed from the CPU; rom_we/rom_addr/
// rom_wdata ROM write port; cpu_reset, busy, halted, halt_pc, cycle_count, timeout status.
// Optional watchdog: define MY_CPU_SEQ_WATCHDOG_EN to halt RUN after MAX_CYCLES cycles.
module my_cpu_sequencer
  import my_cpu_seq_pkg::*;
#(
  parameter int ROM_AW       = 15,
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              load_last,
  input  logic              run,
  input  logic              stop,
  input  logic [PC_W-1:0]   pc,
  input  logic [WORD_W-1:0] instruction,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   halt_pc,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              timeout
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  seq_state_t       state;
  logic [RST_W-1:0] rst_cnt;
  logic [PC_W-1:0]  pc_q1, pc_q2;

  logic             idle_like;
  logic             hi_accept, lo_accept, load_clear;
  logic [CNT_W-1:0] cnt_next;
  logic             halt_hit, wd_hit;

  assign idle_like  = (state == ST_IDLE) || (state == ST_HALTED);
  assign busy       = !idle_like;
  assign hi_accept  = (state == ST_LOAD_HI) && load_valid && load_ready;
  assign lo_accept  = (state == ST_LOAD_LO) && load_valid && load_ready;
  assign load_clear = idle_like && load_start;

  assign cnt_next = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

  // End loop "@X; 0;JMP" executes at X every second cycle, so the current pc matches
  // the pc seen two RUN cycles earlier; the count gate keeps stale history out.
  assign halt_hit = (instruction == HALT_INSTR) && (pc == pc_q2) &&
                    (cycle_count >= CNT_W'(2));

`ifdef MY_CPU_SEQ_WATCHDOG_EN
  // Fires on the edge where the count reaches the limit, so it reads MAX_CYCLES when halted.
  assign wd_hit = (cnt_next == CNT_W'(MAX_CYCLES));
`else
  logic unused_max_cycles;
  assign unused_max_cycles = (MAX_CYCLES != 0);
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      load_ready  <= 1'b0;
      cpu_reset   <= 1'b1;
      halted      <= 1'b0;
      halt_pc     <= '0;
      cycle_count <= '0;
      rst_cnt     <= '0;
      pc_q1       <= '0;
      pc_q2       <= '0;
`ifdef MY_CPU_SEQ_WATCHDOG_EN
      timeout     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          cpu_reset <= 1'b1;
          if (load_start) begin
            state      <= ST_LOAD_HI;
            load_ready <= 1'b1;
            halted     <= 1'b0;
          end else if (run) begin
            state       <= ST_RST_PULSE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
`ifdef MY_CPU_SEQ_WATCHDOG_EN
            timeout     <= 1'b0;
`endif
          end
        end
        ST_LOAD_HI: begin
          if (hi_accept) begin
            if (load_last) begin
              state      <= ST_IDLE;
              load_ready <= 1'b0;
            end else begin
              state <= ST_LOAD_LO;
            end
          end
        end
        ST_LOAD_LO: begin
          if (lo_accept) begin
            if (load_last) begin
              state      <= ST_IDLE;
              load_ready <= 1'b0;
            end else begin
              state <= ST_LOAD_HI;
            end
          end
        end
        ST_RST_PULSE: begin
          if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cycle_count <= cnt_next;
          pc_q1       <= pc;
          pc_q2       <= pc_q1;
          // stop outranks halt detect, which outranks the watchdog; all capture the same pc.
          if (stop || halt_hit || wd_hit) begin
            state     <= ST_HALTED;
            halted    <= 1'b1;
            halt_pc   <= pc;
            cpu_reset <= 1'b1;
`ifdef MY_CPU_SEQ_WATCHDOG_EN
            timeout   <= wd_hit && !stop && !halt_hit;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  my_cpu_seq_loader #(
    .ROM_AW(ROM_AW)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_clear),
    .hi_accept(hi_accept),
    .lo_accept(lo_accept),
    .last     (load_last),
    .data     (load_data),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata)
  );

endmodule
